cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
//
// PURPOSE
// Miss handler sitting directly upstream of memory4c (4-cycle pipelined read, data_valid-tagged).
// On a cache miss it fetches the whole 16-byte block as 8 back-to-back word reads and streams the
// returning words into the cache data array, then writes the tag. Read-only toward memory;
// the parent drives memory wr low while fsm_busy is high.
//
// PARAMETERS
// ADDR_WIDTH       16  byte-address width; matches memory4c ADDR_WIDTH
// WORDS_PER_BLOCK   8  16-bit words per block; power of 2, >= 2
// WSEL_W            3  log2(WORDS_PER_BLOCK); width of word index
//
// PORTS
// clk               in   1           clock, all state on rising edge
// rst               in   1           synchronous, active-high reset
// miss_detected     in   1           cache reports miss this cycle
// miss_address      in   ADDR_WIDTH  byte address that missed (bit 0 ignored)
// memory_data_valid in   1           memory4c data_valid
// memory_data       in   16          memory4c data_out
// fsm_busy          out  1           fill in progress; pipeline must stall
// memory_address    out  ADDR_WIDTH  read address to memory4c
// memory_enable     out  1           read request to memory4c this cycle
// write_data_array  out  1           write fill_data into cache word data_word_sel
// write_tag_array   out  1           one-cycle pulse: write tag/valid for filled block
// data_word_sel     out  WSEL_W      cache word index for current write
// fill_data         out  16          word to write (combinational pass of memory_data)
// crit_word_valid   out  1           requested word arriving this cycle
//
// BEHAVIOUR
// - Reset: state IDLE, counters 0, base addr 0; every output 0 in the reset cycle and after.
// - States: IDLE, FILL. IDLE->FILL when miss_detected sampled high; FILL->IDLE the edge after
//   the final word is written. miss_detected ignored while in FILL.
// - On IDLE->FILL edge: latch base = {miss_address[AW-1:WSEL_W+1], 0...}, start = word index
//   miss_address[WSEL_W:1] (or 0, see CONFIGURATION); issue_cnt=0, ret_cnt=0.
// - Issue: in FILL while issue_cnt<WORDS_PER_BLOCK: memory_enable=1,
//   memory_address = base + 2*((start+issue_cnt) mod WORDS_PER_BLOCK); issue_cnt++ each cycle.
//   Index wraps within block; address never crosses block boundary.
// - Return: in FILL, each cycle memory_data_valid=1: write_data_array=1,
//   data_word_sel=(start+ret_cnt) mod WORDS_PER_BLOCK, fill_data=memory_data, ret_cnt++.
//   Returns accepted in the same cycle issue is still active (overlap required).
// - crit_word_valid=1 exactly in the return cycle with ret_cnt==0 and selected index == start.
// - Last return (ret_cnt==WORDS_PER_BLOCK-1 & valid): write_tag_array=1 same cycle; next edge IDLE.
// - fsm_busy=1 in FILL, combinationally 1 in IDLE cycle where miss_detected=1.
// - Timing (memory latency 4): miss sampled edge N; issues N+1..N+8; returns N+5..N+12;
//   tag pulse cycle N+12; fsm_busy low from N+13. Miss-to-idle = 13 cycles.
// - memory_data_valid in IDLE: ignored, no writes.
// - rst mid-FILL: IDLE next edge, counters cleared, no tag write; partial block stays invalid.
// - memory_enable never asserted in IDLE; no more than WORDS_PER_BLOCK reads per miss.
//
// CONFIGURATION
// CACHE_FILL_CRIT_WORD_FIRST_EN defined: start = missed word index; fetch order rotates from it
//   and wraps (e.g. word 5: 5,6,7,0,1,2,3,4); crit_word_valid pulses on first return.
// Not defined: start forced to 0; order 0..7; crit_word_valid pulses only when missed word is 0,
//   on first return. Latency identical in both builds.
//
// TESTING
// 1. rst high 2 cycles -> all outputs 0; memory_data_valid=1 in IDLE -> no write_data_array.
// 2. miss 0x1234 (macro off) -> addrs 0x1230..0x123E step 2, sel 0..7, tag pulse N+12, idle N+13.
// 3. miss 0x123A (macro on) -> addrs 0x123A,0x123C,0x123E,0x1230..0x1238; crit_word_valid at N+5 sel 5.
// 4. miss 0xFFFE (macro on) -> wrap stays 0xFFF0..0xFFFE, no 0x0000 access; sel 7 first.
// 5. second miss_detected during FILL -> ignored, exactly 8 enables, one tag pulse.
// 6. rst at N+7 mid-fill -> IDLE at N+8, no tag pulse; new miss afterwards completes normally.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm -- cache miss handler in front of memory4c (4-cycle pipelined read).
//
// A cache miss starts a fill of the whole block. The block is fetched as WORDS_PER_BLOCK
// back-to-back word reads. The returning words are streamed into the cache data array, and
// the tag is written on the final return.
//
// Build option: CACHE_FILL_CRIT_WORD_FIRST_EN
//   defined   : the fetch starts at the missed word and wraps within the block.
//   undefined : the fetch always starts at word 0.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   miss_detected      cache miss this cycle (ignored while filling)
//   miss_address       byte address that missed (bit 0 ignored)
//   memory_data_valid  memory4c data_valid
//   memory_data        memory4c data_out
//   fsm_busy           fill in progress, pipeline stalls
//   memory_address     word read address to memory4c
//   memory_enable      read request this cycle
//   write_data_array   write fill_data into cache word data_word_sel
//   write_tag_array    one-cycle tag/valid write for the filled block
//   data_word_sel      cache word index of the current write
//   fill_data          returning word (memory_data while writing, else 0)
//   crit_word_valid    the requested word is being written this cycle
module cache_fill_fsm #(
   parameter int ADDR_WIDTH      = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int WSEL_W          = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   input  logic                  memory_data_valid,
   input  logic [15:0]           memory_data,
   output logic                  fsm_busy,
   output logic [ADDR_WIDTH-1:0] memory_address,
   output logic                  memory_enable,
   output logic                  write_data_array,
   output logic                  write_tag_array,
   output logic [WSEL_W-1:0]     data_word_sel,
   output logic [15:0]           fill_data,
   output logic                  crit_word_valid
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic [WSEL_W-1:0] SEL_ONE  = WSEL_W'(1);
   localparam logic [WSEL_W-1:0] SEL_LAST = WSEL_W'(WORDS_PER_BLOCK - 1);
   localparam logic [WSEL_W:0]   ISS_ONE  = (WSEL_W+1)'(1);

   state_t                       state, state_nxt;
   logic [ADDR_WIDTH-WSEL_W-2:0] base_hi;
   logic [WSEL_W-1:0]            start_idx;
   logic [WSEL_W-1:0]            miss_idx;
   logic [WSEL_W:0]              issue_cnt;
   logic [WSEL_W-1:0]            ret_cnt;

   logic [WSEL_W-1:0]            req_idx;
   logic [WSEL_W-1:0]            issue_idx;
   logic [WSEL_W-1:0]            ret_idx;
   logic                         issuing;
   logic                         returning;
   logic                         last_ret;
   logic                         unused_addr_lsb;

   assign req_idx         = miss_address[WSEL_W:1];
   assign unused_addr_lsb = miss_address[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base_hi   <= '0;
         start_idx <= '0;
         miss_idx  <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && miss_detected) begin
            base_hi   <= miss_address[ADDR_WIDTH-1:WSEL_W+1];
            miss_idx  <= req_idx;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            start_idx <= req_idx;
`else
            start_idx <= '0;
`endif
            issue_cnt <= '0;
            ret_cnt   <= '0;
         end else if (state == FILL) begin
            if (issuing)
               issue_cnt <= issue_cnt + ISS_ONE;
            if (returning)
               ret_cnt <= ret_cnt + SEL_ONE;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      fsm_busy         = 1'b0;
      memory_address   = '0;
      memory_enable    = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      data_word_sel    = '0;
      fill_data        = '0;
      crit_word_valid  = 1'b0;

      // The block size is a power of two, so issue_cnt < WORDS_PER_BLOCK is exactly "MSB clear".
      // The word indices wrap modulo the block size through the natural WSEL_W-bit overflow.
      issuing   = (state == FILL) && !issue_cnt[WSEL_W];
      returning = (state == FILL) && memory_data_valid;
      last_ret  = returning && (ret_cnt == SEL_LAST);
      issue_idx = start_idx + issue_cnt[WSEL_W-1:0];
      ret_idx   = start_idx + ret_cnt;

      unique case (state)
         IDLE: if (miss_detected) state_nxt = FILL;
         FILL: if (last_ret)      state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase

      // All outputs are held at 0 during a reset cycle, including in the middle of a fill.
      if (!rst) begin
         fsm_busy        = (state == FILL) || miss_detected;
         memory_enable   = issuing;
         write_tag_array = last_ret;
         if (issuing)
            memory_address = {base_hi, issue_idx, 1'b0};
         if (returning) begin
            write_data_array = 1'b1;
            data_word_sel    = ret_idx;
            fill_data        = memory_data;
            crit_word_valid  = (ret_cnt == '0) && (start_idx == miss_idx);
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm -- self-checking bench for cache_fill_fsm.
//
// The bench contains a 4-cycle pipelined memory that serves the reads the DUT issues. It
// contains a timeline model of one fill. The model counts cycles since the miss was sampled,
// and the expected outputs of each cycle follow from that count.
module tb_cache_fill_fsm;
   localparam int AW  = 16;
   localparam int WPB = 8;
   localparam int WS  = 3;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          miss_detected;
   logic [AW-1:0] miss_address;
   logic          memory_data_valid;
   logic [15:0]   memory_data;
   logic          fsm_busy;
   logic [AW-1:0] memory_address;
   logic          memory_enable;
   logic          write_data_array;
   logic          write_tag_array;
   logic [WS-1:0] data_word_sel;
   logic [15:0]   fill_data;
   logic          crit_word_valid;

   cache_fill_fsm #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB), .WSEL_W(WS)) dut (
      .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
      .memory_data_valid(memory_data_valid), .memory_data(memory_data),
      .fsm_busy(fsm_busy), .memory_address(memory_address), .memory_enable(memory_enable),
      .write_data_array(write_data_array), .write_tag_array(write_tag_array),
      .data_word_sel(data_word_sel), .fill_data(fill_data), .crit_word_valid(crit_word_valid)
   );

   always #5 clk = ~clk;

   int unsigned vecs = 0;
   int unsigned errs = 0;
   logic [15:0] salt;

   // memory pipeline
   logic          pv[LAT];
   logic [AW-1:0] pa[LAT];
   logic          req_v;
   logic [AW-1:0] req_a;

   // reference timeline
   bit            m_fill;
   int            m_k;
   int            m_start;
   int            m_idx;
   logic [AW-1:0] m_base;
   int            n_en;
   int            n_tag;

   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      logic [15:0] t;
      t = a * 16'h9E37;
      return t ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. The task is entered just after a rising edge: it drives the inputs,
   // checks the outputs at the falling edge, then advances the memory and the model.
   task automatic do_cycle(input logic r, input logic m, input logic [AW-1:0] a, input logic spur);
      logic          e_busy, e_en, e_wr, e_tag, e_crit;
      logic [AW-1:0] e_addr;
      int            e_sel;
      rst           = r;
      miss_detected = m;
      miss_address  = a;
      memory_data_valid = pv[LAT-1] | spur;
      memory_data   = pv[LAT-1] ? mem_word(pa[LAT-1]) : 16'($urandom);
      @(negedge clk);
      e_busy = 0; e_en = 0; e_wr = 0; e_tag = 0; e_crit = 0; e_addr = '0; e_sel = 0;
      if (!r) begin
         if (!m_fill) e_busy = m;
         else begin
            e_busy = 1;
            e_en   = (m_k <= WPB);
            e_addr = m_base + AW'(2 * ((m_start + m_k - 1) % WPB));
            e_wr   = (m_k >= LAT + 1);
            e_sel  = e_wr ? (m_start + m_k - LAT - 1) % WPB : 0;
            e_tag  = (m_k == WPB + LAT);
            e_crit = (m_k == LAT + 1) && (m_start == m_idx);
         end
      end
      chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
      chk("memory_enable", 32'(memory_enable), 32'(e_en));
      chk("write_data_array", 32'(write_data_array), 32'(e_wr));
      chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
      chk("crit_word_valid", 32'(crit_word_valid), 32'(e_crit));
      if (e_en || r) chk("memory_address", 32'(memory_address), 32'(e_addr));
      if (e_wr || r) chk("data_word_sel", 32'(data_word_sel), 32'(e_sel));
      if (e_wr) chk("fill_data", 32'(fill_data), 32'(mem_word(m_base + AW'(2 * e_sel))));
      if (r) chk("fill_data_rst", 32'(fill_data), 32'h0);
      if (memory_enable) n_en++;
      if (write_tag_array) n_tag++;
      req_v = memory_enable;
      req_a = memory_address;
      if (r) m_fill = 0;
      else if (!m_fill) begin
         if (m) begin
            m_fill = 1;
            m_k    = 1;
            m_base = {a[AW-1:WS+1], {(WS+1){1'b0}}};
            m_idx  = int'(a[WS:1]);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            m_start = m_idx;
`else
            m_start = 0;
`endif
         end
      end else if (m_k == WPB + LAT) m_fill = 0;
      else m_k++;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0] = req_v;
      pa[0] = req_a;
   endtask

   // Full miss: noisy miss_detected is applied while the fill runs. It must be ignored.
   task automatic run_miss(input logic [AW-1:0] a, input bit noise);
      n_en = 0; n_tag = 0;
      do_cycle(1'b0, 1'b1, a, 1'b0);
      for (int i = 0; i < WPB + LAT; i++)
         do_cycle(1'b0, noise ? 1'($urandom) : 1'b0, AW'($urandom), 1'b0);
      for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b0, AW'($urandom), 1'b0);
      chk("n_enables", 32'(n_en), WPB);
      chk("n_tags", 32'(n_tag), 1);
   endtask

   initial begin
      salt = 16'($urandom);
      rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
      memory_data_valid = 1'b0; memory_data = '0;
      m_fill = 0; m_k = 0; m_start = 0; m_idx = 0; m_base = '0; n_en = 0; n_tag = 0;
      req_v = 1'b0; req_a = '0;
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      @(posedge clk); #1;

      // reset, then stray data_valid while idle
      do_cycle(1'b1, 1'b1, 16'h1234, 1'b1);
      do_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, AW'($urandom), 1'b1);

      // directed addresses: mid-block, rotated start, top of address space
      run_miss(16'h1234, 0);
      run_miss(16'h123A, 0);
      run_miss(16'hFFFE, 0);
      run_miss(16'h0000, 0);

      // second miss_detected while filling
      run_miss(16'h4C56, 1);

      // reset mid-fill at N+7, drain memory, then a normal fill
      n_en = 0; n_tag = 0;
      do_cycle(1'b0, 1'b1, 16'h2468, 1'b0);
      for (int i = 1; i < 7; i++) do_cycle(1'b0, 1'b0, '0, 1'b0);
      do_cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, AW'($urandom), 1'b0);
      chk("rst_mid_fill_tags", 32'(n_tag), 0);
      chk("rst_mid_fill_enables", 32'(n_en), 6);
      run_miss(16'h2468, 0);

      // randomized misses with stray data_valid between them
      for (int j = 0; j < 20; j++) begin
         run_miss(AW'($urandom), 1'($urandom));
         do_cycle(1'b0, 1'b0, AW'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
